// File: rtl/thor2022_mmu_walk_arb_if.sv
// Thor2022 MMU walk arbiter bus: three miss requesters on one side,
// the shared page-table-walk engine on the other.
// Signals:
//   req_i/adr0_i..adr2_i    requests and addresses from ITLB, DTLB, PMT
//   gnt_o/done_o/err_o      owner grant, completion pulse, error flag
//   walk_req_o/adr/src      start pulse, address and owner to the engine
//   walk_ack_i/walk_err_i   engine completion and fault
// Modports: master = arbiter, slave = requesters plus walk engine.
interface thor2022_mmu_walk_arb_if #(
    parameter int AW = 32
);
    logic [2:0]    req_i;
    logic [AW-1:0] adr0_i;
    logic [AW-1:0] adr1_i;
    logic [AW-1:0] adr2_i;
    logic [2:0]    gnt_o;
    logic [2:0]    done_o;
    logic          err_o;
    logic          walk_req_o;
    logic [AW-1:0] walk_adr_o;
    logic [1:0]    walk_src_o;
    logic          walk_ack_i;
    logic          walk_err_i;

    modport master (
        input  req_i, adr0_i, adr1_i, adr2_i,
        input  walk_ack_i, walk_err_i,
        output gnt_o, done_o, err_o,
        output walk_req_o, walk_adr_o, walk_src_o
    );

    modport slave (
        output req_i, adr0_i, adr1_i, adr2_i,
        output walk_ack_i, walk_err_i,
        input  gnt_o, done_o, err_o,
        input  walk_req_o, walk_adr_o, walk_src_o
    );
endinterface

// File: rtl/thor2022_mmu_walk_arb.sv
// Round-robin arbiter sharing one page-table-walk engine between
// ITLB (0), DTLB (1) and PMT fetch (2), with a walk timeout.
// Ports:
//   clk_i   clock, all state on its rising edge
//   rst_ni  synchronous active-low reset
//   bus     thor2022_mmu_walk_arb_if.master (requesters + engine)
module thor2022_mmu_walk_arb #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    thor2022_mmu_walk_arb_if.master        bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    done_q, done_d;
    logic          err_q, err_d;
    logic          wreq_q, wreq_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [1:0]    src_q, src_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    last_q, last_d;

    logic [1:0]    pick;
    logic [1:0]    cand;
    logic          found;
    logic [AW-1:0] pick_adr;

    // Search starts one past the last owner and wraps modulo 3.
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        cand  = last_q;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        unique case (pick)
            2'd1:    pick_adr = bus.adr1_i;
            2'd2:    pick_adr = bus.adr2_i;
            default: pick_adr = bus.adr0_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 3'b000;
        err_d   = err_q;
        wreq_d  = 1'b0;
        adr_d   = adr_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = 3'b001 << pick;
                    src_d   = pick;
                    adr_d   = pick_adr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Registered, so the pulse lands in the first WAIT cycle.
                wreq_d  = 1'b1;
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (bus.walk_ack_i) begin
                    done_d  = gnt_q;
                    err_d   = bus.walk_err_i;
                    state_d = DONE;
                end else if (cnt_q == TO_M1) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                last_d  = src_q;
                gnt_d   = 3'b000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            err_q   <= 1'b0;
            wreq_q  <= 1'b0;
            adr_q   <= '0;
            src_q   <= 2'd0;
            cnt_q   <= 8'd0;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wreq_q  <= wreq_d;
            adr_q   <= adr_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.walk_req_o = wreq_q;
    assign bus.walk_adr_o = adr_q;
    assign bus.walk_src_o = src_q;
endmodule

// File: tb/tb_thor2022_mmu_walk_arb.sv
// Directed bench for thor2022_mmu_walk_arb: a cycle table for grants,
// round robin and faults, plus sequences for timeout and reset cases.
module tb_thor2022_mmu_walk_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    thor2022_mmu_walk_arb_if #(.AW(32)) bus();

    thor2022_mmu_walk_arb #(
        .TIMEOUT(255),
        .AW(32)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_4000;
    localparam logic [31:0] A2 = 32'h0000_9000;

    typedef struct {
        logic        rst_n;
        logic [2:0]  req;
        logic        ack;
        logic        werr;
        logic [2:0]  gnt;
        logic [2:0]  done;
        logic        err;
        logic        wreq;
        logic [1:0]  src;
        logic [31:0] adr;
    } vec_t;

    vec_t vecs[$];
    int n_run = 0;
    int n_fail = 0;

    function automatic vec_t mk(
        input logic r, input logic [2:0] q, input logic a, input logic e,
        input logic [2:0] g, input logic [2:0] d, input logic er,
        input logic w, input logic [1:0] s, input logic [31:0] ad);
        vec_t v;
        v.rst_n = r; v.req = q; v.ack = a; v.werr = e;
        v.gnt = g; v.done = d; v.err = er; v.wreq = w;
        v.src = s; v.adr = ad;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [2:0] q,
                         input logic a, input logic e);
        rst_n          = r;
        bus.req_i      = q;
        bus.walk_ack_i = a;
        bus.walk_err_i = e;
    endtask

    task automatic chk_all(input string t, input logic [2:0] g,
                           input logic [2:0] d, input logic er,
                           input logic w, input logic [1:0] s,
                           input logic [31:0] ad);
        chk({t, ".gnt"}, 32'(bus.gnt_o), 32'(g));
        chk({t, ".done"}, 32'(bus.done_o), 32'(d));
        chk({t, ".err"}, 32'(bus.err_o), 32'(er));
        chk({t, ".wreq"}, 32'(bus.walk_req_o), 32'(w));
        chk({t, ".src"}, 32'(bus.walk_src_o), 32'(s));
        chk({t, ".adr"}, bus.walk_adr_o, ad);
    endtask

    initial begin
        int n;
        bus.adr0_i = A0;
        bus.adr1_i = A1;
        bus.adr2_i = A2;
        drive(1'b0, 3'b000, 1'b0, 1'b0);

        // Reset, single DTLB walk acked after 5 waits, then round robin.
        vecs.push_back(mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 0, 3'b010, 3'b000, 0, 0, 1, A1));
        vecs.push_back(mk(1, 3'b010, 0, 0, 3'b010, 3'b000, 0, 1, 1, A1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 3'b010, 0, 0, 3'b010, 3'b000, 0, 0, 1, A1));
        vecs.push_back(mk(1, 3'b010, 1, 0, 3'b010, 3'b010, 0, 0, 1, A1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 1, A1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 1, A1));
        vecs.push_back(mk(0, 3'b111, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b001, 3'b000, 0, 0, 0, A0));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b001, 3'b000, 0, 1, 0, A0));
        vecs.push_back(mk(1, 3'b111, 1, 0, 3'b001, 3'b001, 0, 0, 0, A0));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b000, 3'b000, 0, 0, 0, A0));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b010, 3'b000, 0, 0, 1, A1));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b010, 3'b000, 0, 1, 1, A1));
        vecs.push_back(mk(1, 3'b111, 1, 1, 3'b010, 3'b010, 1, 0, 1, A1));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b000, 3'b000, 1, 0, 1, A1));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b100, 3'b000, 1, 0, 2, A2));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b100, 3'b000, 1, 1, 2, A2));
        vecs.push_back(mk(1, 3'b111, 1, 0, 3'b100, 3'b100, 0, 0, 2, A2));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b000, 3'b000, 0, 0, 2, A2));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b001, 3'b000, 0, 0, 0, A0));
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'b001, 3'b000, 0, 1, 0, A0));
        vecs.push_back(mk(1, 3'b111, 1, 0, 3'b001, 3'b001, 0, 0, 0, A0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, A0));
        vecs.push_back(mk(1, 3'b000, 1, 1, 3'b000, 3'b000, 0, 0, 0, A0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, A0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].req, vecs[i].ack, vecs[i].werr);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done,
                    vecs[i].err, vecs[i].wreq, vecs[i].src, vecs[i].adr);
        end

        // Timeout on requester 2 (last owner was 0, only 2 requests).
        drive(1'b1, 3'b100, 1'b0, 1'b0);
        tick();
        chk_all("to_gnt", 3'b100, 3'b000, 0, 0, 2, A2);
        tick();
        chk("to_wreq", 32'(bus.walk_req_o), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done_o == 3'b000 && n < 300);
        chk("to_cycles", n, 255);
        chk("to_done", 32'(bus.done_o), 32'b100);
        chk("to_err", 32'(bus.err_o), 32'd1);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        chk_all("to_end", 3'b000, 3'b000, 1, 0, 2, A2);

        // Ack on the same edge the timeout would fire: ack wins.
        drive(1'b1, 3'b100, 1'b0, 1'b0);
        tick();
        chk("co_gnt", 32'(bus.gnt_o), 32'b100);
        tick();
        for (int i = 0; i < 254; i++) tick();
        chk("co_nodone", 32'(bus.done_o), 32'd0);
        drive(1'b1, 3'b100, 1'b1, 1'b0);
        tick();
        chk("co_done", 32'(bus.done_o), 32'b100);
        chk("co_err", 32'(bus.err_o), 32'd0);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        tick();

        // Reset mid-WAIT, late ack ignored, then 110 grants requester 1.
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        chk("rs_gnt", 32'(bus.gnt_o), 32'b001);
        tick();
        tick();
        tick();
        drive(1'b0, 3'b001, 1'b0, 1'b0);
        tick();
        chk_all("rs_zero", 3'b000, 3'b000, 0, 0, 0, 0);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b000, 1'b1, 1'b1);
        tick();
        chk_all("rs_late", 3'b000, 3'b000, 0, 0, 0, 0);
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        tick();
        chk_all("rs_next", 3'b010, 3'b000, 0, 0, 1, A1);
        drive(1'b1, 3'b010, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b010, 1'b1, 1'b0);
        tick();
        chk("rs_done", 32'(bus.done_o), 32'b010);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        tick();

        // Owner drops its request mid-walk; completion still reaches it.
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        tick();
        chk("dr_gnt", 32'(bus.gnt_o), 32'b001);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        chk("dr_hold", 32'(bus.gnt_o), 32'b001);
        tick();
        drive(1'b1, 3'b000, 1'b1, 1'b0);
        tick();
        chk("dr_done", 32'(bus.done_o), 32'b001);
        chk("dr_src", 32'(bus.walk_src_o), 32'd0);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        chk("dr_idle", 32'(bus.gnt_o), 32'd0);
        chk("dr_pulse", 32'(bus.done_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
